// File: rtl/data_bus_responder.sv
// Single-cycle data-bus responder: word-addressed scratch RAM plus an MMIO page
// (LED register, free-running timer with compare/IRQ, synchronized switches).
module data_bus_responder #(
  parameter int unsigned RAM_WORDS = 512,
  parameter int unsigned SW_WIDTH  = 16,
  parameter int unsigned LED_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [9:0]           daddr,
  input  logic [31:0]          ddata_w,
  input  logic                 d_w,
  input  logic                 d_r,
  output logic [31:0]          ddata_r,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 irq,
  output logic                 bus_err
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [9:0] A_LED    = 10'h3F0;
  localparam logic [9:0] A_MTIME  = 10'h3F1;
  localparam logic [9:0] A_MTCMP  = 10'h3F2;
  localparam logic [9:0] A_STATUS = 10'h3F3;
  localparam logic [9:0] A_SW     = 10'h3F4;
  localparam logic [9:0] A_CTRL   = 10'h3F5;

  logic [31:0]         ram [RAM_WORDS];
  logic [31:0]         led_q;
  logic [31:0]         mtime;
  logic [31:0]         mtimecmp;
  logic                match_q;
  logic                irq_en;
  logic                cnt_en;
  logic [SW_WIDTH-1:0] sync1;
  logic [SW_WIDTH-1:0] sync2;
  logic                err_q;

  logic          ram_hit;
  logic          mapped;
  logic [AW-1:0] ram_idx;
  logic          match_set;
  logic          w1c;

  assign ram_hit   = ({22'b0, daddr} < RAM_WORDS);
  assign mapped    = ram_hit || (daddr >= A_LED && daddr <= A_CTRL);
  assign ram_idx   = daddr[AW-1:0];
  assign match_set = cnt_en && (mtime == mtimecmp);
  assign w1c       = d_w && (daddr == A_STATUS) && ddata_w[0];

  always_comb begin
    ddata_r = '0;
    if (d_r) begin
      if (ram_hit) begin
        ddata_r = ram[ram_idx];
      end else begin
        case (daddr)
          A_LED:    ddata_r = led_q;
          A_MTIME:  ddata_r = mtime;
          A_MTCMP:  ddata_r = mtimecmp;
          A_STATUS: ddata_r = {31'b0, match_q};
          A_SW:     ddata_r[SW_WIDTH-1:0] = sync2;
          A_CTRL:   ddata_r = {30'b0, cnt_en, irq_en};
          default:  ddata_r = '0;
        endcase
      end
    end
  end

  // RAM has no reset, but a write coinciding with RST is still dropped.
  always_ff @(posedge CLK) begin
    if (!RST && d_w && ram_hit) begin
      ram[ram_idx] <= ddata_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      led_q    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      match_q  <= 1'b0;
      irq_en   <= 1'b0;
      cnt_en   <= 1'b0;
      sync1    <= '0;
      sync2    <= '0;
      err_q    <= 1'b0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      err_q <= (d_r || d_w) && !mapped;

      if (d_w && daddr == A_LED)   led_q    <= ddata_w;
      if (d_w && daddr == A_MTCMP) mtimecmp <= ddata_w;
      if (d_w && daddr == A_CTRL) begin
        irq_en <= ddata_w[0];
        cnt_en <= ddata_w[1];
      end

      if (d_w && daddr == A_MTIME) mtime <= ddata_w;
      else if (cnt_en)             mtime <= mtime + 32'd1;

      // A match in the same cycle as a W1C keeps the flag set.
      match_q <= match_set || (match_q && !w1c);
    end
  end

  assign leds    = led_q[LED_WIDTH-1:0];
  assign irq     = match_q && irq_en;
  assign bus_err = err_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed-vector bench for data_bus_responder: a table of single-cycle vectors
// plus hand-written multi-cycle sequences for the timer, sync and reset cases.
module tb_data_bus_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  daddr = '0;
  logic [31:0] ddata_w = '0;
  logic        d_w = 1'b0;
  logic        d_r = 1'b0;
  logic [31:0] ddata_r;
  logic [15:0] sw_in = '0;
  logic [15:0] leds;
  logic        irq;
  logic        bus_err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  data_bus_responder #(.RAM_WORDS(512), .SW_WIDTH(16), .LED_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r),
    .ddata_r(ddata_r), .sw_in(sw_in), .leds(leds), .irq(irq), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    bit          rst;
    logic [9:0]  addr;
    bit          w;
    bit          r;
    logic [31:0] wd;
    logic [15:0] sw;
    logic [31:0] exp_rd;
    logic [15:0] exp_leds;
    bit          exp_irq;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, bit rst, logic [9:0] a, bit w, bit r,
                              logic [31:0] wd, logic [15:0] sw, logic [31:0] erd,
                              logic [15:0] eled, bit eirq, bit eerr);
    vec_t t;
    t.name = n; t.rst = rst; t.addr = a; t.w = w; t.r = r; t.wd = wd; t.sw = sw;
    t.exp_rd = erd; t.exp_leds = eled; t.exp_irq = eirq; t.exp_err = eerr;
    return t;
  endfunction

  // Inputs change after the falling edge; outputs are checked just before the rising edge.
  task automatic step(input vec_t t);
    @(negedge CLK);
    RST = t.rst; daddr = t.addr; d_w = t.w; d_r = t.r; ddata_w = t.wd; sw_in = t.sw;
    #1;
    vectors++;
    if (ddata_r !== t.exp_rd || leds !== t.exp_leds || irq !== t.exp_irq || bus_err !== t.exp_err) begin
      miscompares++;
      $display("FAIL %s: got rd=%h leds=%h irq=%b err=%b, expected rd=%h leds=%h irq=%b err=%b",
               t.name, ddata_r, leds, irq, bus_err, t.exp_rd, t.exp_leds, t.exp_irq, t.exp_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // name, rst, addr, w, r, wd, sw, exp_rd, exp_leds, exp_irq, exp_err
    tbl.push_back(mk("rst_led",      0, 10'h3F0, 0, 1, 0,            0, 32'h0,        16'h0,    0, 0));
    tbl.push_back(mk("rst_mtcmp",    0, 10'h3F2, 0, 1, 0,            0, 32'hFFFFFFFF, 16'h0,    0, 0));
    tbl.push_back(mk("rst_mtime",    0, 10'h3F1, 0, 1, 0,            0, 32'h0,        16'h0,    0, 0));
    tbl.push_back(mk("rst_ctrl",     0, 10'h3F5, 0, 1, 0,            0, 32'h0,        16'h0,    0, 0));
    tbl.push_back(mk("rst_status",   0, 10'h3F3, 0, 1, 0,            0, 32'h0,        16'h0,    0, 0));
    tbl.push_back(mk("ram_wr5",      0, 10'h005, 1, 0, 32'hDEADBEEF, 0, 32'h0,        16'h0,    0, 0));
    tbl.push_back(mk("ram_rd5",      0, 10'h005, 0, 1, 0,            0, 32'hDEADBEEF, 16'h0,    0, 0));
    tbl.push_back(mk("ram_nord",     0, 10'h005, 0, 0, 0,            0, 32'h0,        16'h0,    0, 0));
    tbl.push_back(mk("ram_wr10",     0, 10'h010, 1, 0, 32'h11111111, 0, 32'h0,        16'h0,    0, 0));
    tbl.push_back(mk("rdw_old",      0, 10'h010, 1, 1, 32'h22222222, 0, 32'h11111111, 16'h0,    0, 0));
    tbl.push_back(mk("rdw_new",      0, 10'h010, 0, 1, 0,            0, 32'h22222222, 16'h0,    0, 0));
    tbl.push_back(mk("led_wr",       0, 10'h3F0, 1, 0, 32'h12345678, 0, 32'h0,        16'h0,    0, 0));
    tbl.push_back(mk("led_rd",       0, 10'h3F0, 0, 1, 0,            0, 32'h12345678, 16'h5678, 0, 0));
    tbl.push_back(mk("unmap_rd",     0, 10'h3FA, 0, 1, 0,            0, 32'h0,        16'h5678, 0, 0));
    tbl.push_back(mk("err_pulse",    0, 10'h000, 0, 0, 0,            0, 32'h0,        16'h5678, 0, 1));
    tbl.push_back(mk("err_clear",    0, 10'h000, 0, 0, 0,            0, 32'h0,        16'h5678, 0, 0));
    tbl.push_back(mk("sw_wr_ign",    0, 10'h3F4, 1, 0, 32'hFFFFFFFF, 0, 32'h0,        16'h5678, 0, 0));
    tbl.push_back(mk("sw_rd0",       0, 10'h3F4, 0, 1, 0,            0, 32'h0,        16'h5678, 0, 0));
    tbl.push_back(mk("unmap_wr",     0, 10'h3FF, 1, 0, 32'hFFFFFFFF, 0, 32'h0,        16'h5678, 0, 0));
    tbl.push_back(mk("err_after_wr", 0, 10'h3F3, 0, 1, 0,            0, 32'h0,        16'h5678, 0, 1));
    tbl.push_back(mk("ram_past_end", 0, 10'h200, 0, 1, 0,            0, 32'h0,        16'h5678, 0, 0));
    tbl.push_back(mk("ram_wr_last",  0, 10'h1FF, 1, 0, 32'hA5A50001, 0, 32'h0,        16'h5678, 0, 1));
    tbl.push_back(mk("ram_rd_last",  0, 10'h1FF, 0, 1, 0,            0, 32'hA5A50001, 16'h5678, 0, 0));

    RST = 1'b1;
    repeat (2) @(posedge CLK);

    foreach (tbl[i]) step(tbl[i]);

    // Timer: compare at 10, counter starts the edge after CTRL is written.
    step(mk("cmp_wr10",   0, 10'h3F2, 1, 0, 32'd10, 0, 0, 16'h5678, 0, 0));
    step(mk("ctrl_wr3",   0, 10'h3F5, 1, 0, 32'd3,  0, 0, 16'h5678, 0, 0));
    for (int i = 0; i <= 10; i++)
      step(mk("mtime_count", 0, 10'h3F1, 0, 1, 0, 0, 32'(i), 16'h5678, 0, 0));
    step(mk("match_irq",  0, 10'h3F3, 0, 1, 0,      0, 32'd1, 16'h5678, 1, 0));
    step(mk("w1c_wr",     0, 10'h3F3, 1, 0, 32'd1,  0, 0,     16'h5678, 1, 0));
    step(mk("w1c_done",   0, 10'h3F3, 0, 1, 0,      0, 32'd0, 16'h5678, 0, 0));
    step(mk("ctrl_wr2",   0, 10'h3F5, 1, 0, 32'd2,  0, 0,     16'h5678, 0, 0));
    step(mk("mtime_wr8",  0, 10'h3F1, 1, 0, 32'd8,  0, 0,     16'h5678, 0, 0));
    for (int i = 8; i <= 11; i++)
      step(mk("mtime_count2", 0, 10'h3F1, 0, 1, 0, 0, 32'(i), 16'h5678, 0, 0));
    step(mk("match_noirq", 0, 10'h3F3, 0, 1, 0,     0, 32'd1, 16'h5678, 0, 0));

    // Wrap, then W1C colliding with a match.
    step(mk("w1c_wr2",    0, 10'h3F3, 1, 0, 32'd1,        0, 0,            16'h5678, 0, 0));
    step(mk("status_0",   0, 10'h3F3, 0, 1, 0,            0, 32'd0,        16'h5678, 0, 0));
    step(mk("mtime_wrFE", 0, 10'h3F1, 1, 0, 32'hFFFFFFFE, 0, 0,            16'h5678, 0, 0));
    step(mk("wrap_FE",    0, 10'h3F1, 0, 1, 0,            0, 32'hFFFFFFFE, 16'h5678, 0, 0));
    step(mk("wrap_FF",    0, 10'h3F1, 0, 1, 0,            0, 32'hFFFFFFFF, 16'h5678, 0, 0));
    step(mk("wrap_00",    0, 10'h3F1, 0, 1, 0,            0, 32'h0,        16'h5678, 0, 0));
    step(mk("mtime_wr100",0, 10'h3F1, 1, 0, 32'h100,      0, 0,            16'h5678, 0, 0));
    step(mk("cmp_wr102",  0, 10'h3F2, 1, 0, 32'h102,      0, 0,            16'h5678, 0, 0));
    step(mk("pre_match",  0, 10'h3F3, 0, 1, 0,            0, 32'd0,        16'h5678, 0, 0));
    step(mk("w1c_vs_set", 0, 10'h3F3, 1, 0, 32'd1,        0, 0,            16'h5678, 0, 0));
    step(mk("set_wins",   0, 10'h3F3, 0, 1, 0,            0, 32'd1,        16'h5678, 0, 0));
    step(mk("ctrl_wr3b",  0, 10'h3F5, 1, 0, 32'd3,        0, 0,            16'h5678, 0, 0));
    step(mk("irq_on_en",  0, 10'h3F3, 0, 1, 0,            0, 32'd1,        16'h5678, 1, 0));
    step(mk("w1c_wr3",    0, 10'h3F3, 1, 0, 32'd1,        0, 0,            16'h5678, 1, 0));
    step(mk("irq_off",    0, 10'h3F3, 0, 1, 0,            0, 32'd0,        16'h5678, 0, 0));
    step(mk("ctrl_wr0",   0, 10'h3F5, 1, 0, 32'd0,        0, 0,            16'h5678, 0, 0));
    step(mk("hold_a",     0, 10'h3F1, 0, 1, 0,            0, 32'h109,      16'h5678, 0, 0));
    step(mk("hold_b",     0, 10'h3F1, 0, 1, 0,            0, 32'h109,      16'h5678, 0, 0));

    // Switch synchronizer latency.
    step(mk("sw_edge0",   0, 10'h3F4, 0, 1, 0, 16'hA5A5, 32'h0,      16'h5678, 0, 0));
    step(mk("sw_edge1",   0, 10'h3F4, 0, 1, 0, 16'hA5A5, 32'h0,      16'h5678, 0, 0));
    step(mk("sw_edge2",   0, 10'h3F4, 0, 1, 0, 16'hA5A5, 32'h0000A5A5, 16'h5678, 0, 0));

    // Reset during a write, with an error pulse pending.
    step(mk("ctrl_wr2b",  0, 10'h3F5, 1, 0, 32'd2,    16'hA5A5, 0,            16'h5678, 0, 0));
    step(mk("pre_rst_err",0, 10'h3FA, 0, 1, 0,        16'hA5A5, 0,            16'h5678, 0, 0));
    step(mk("rst_w_led",  1, 10'h3F0, 1, 0, 32'hFFFF, 16'hA5A5, 0,            16'h5678, 0, 1));
    step(mk("post_led",   0, 10'h3F0, 0, 1, 0,        16'hA5A5, 32'h0,        16'h0,    0, 0));
    step(mk("post_mtime", 0, 10'h3F1, 0, 1, 0,        16'hA5A5, 32'h0,        16'h0,    0, 0));
    step(mk("post_cmp",   0, 10'h3F2, 0, 1, 0,        16'hA5A5, 32'hFFFFFFFF, 16'h0,    0, 0));
    step(mk("post_ram",   0, 10'h005, 0, 1, 0,        16'hA5A5, 32'hDEADBEEF, 16'h0,    0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Single-cycle data-bus responder for the RV32 core's data port.
- Serves `daddr`/`d_r`/`d_w` with a word-addressed scratch RAM and a small MMIO page: LED output register, 32-bit free-running timer with compare/IRQ, and a synchronized switch input.
- Read data is combinational, so the core completes loads in one cycle.
- Writes commit on the rising clock edge.

Parameters:
- RAM_WORDS, 512, number of 32-bit RAM words mapped at word addresses 0..RAM_WORDS-1 (must be ≤ 1008).
- SW_WIDTH, 16, width of switch input.
- LED_WIDTH, 16, width of LED output.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- daddr  in  10  word address (byte address bits [11:2]).
- ddata_w  in  32  write data.
- d_w  in  1  write strobe, full-word write this cycle.
- d_r  in  1  read strobe.
- ddata_r  out  32  read data, combinational from daddr/state.
- sw_in  in  SW_WIDTH  asynchronous switch inputs.
- leds  out  LED_WIDTH  LED register, low bits.
- irq  out  1  timer interrupt level.
- bus_err  out  1  registered one-cycle pulse on an unmapped access.

Behaviour:
- Address map (word addresses):
  - 0..RAM_WORDS-1: RAM.
  - 0x3F0: LED (RW).
  - 0x3F1: MTIME (RW).
  - 0x3F2: MTIMECMP (RW).
  - 0x3F3: STATUS (bit0 = match, W1C; other bits read 0).
  - 0x3F4: SW (RO).
  - 0x3F5: CTRL (bit0 irq_en, bit1 cnt_en; other bits read 0).
  - Everything else is unmapped.
- Reset values: LED=0, MTIME=0, MTIMECMP=0xFFFFFFFF, STATUS=0, CTRL=0, both sync stages=0, bus_err=0. Hence leds=0, irq=0.
- RAM contents are not reset.
- Read path:
  - ddata_r = mapped value when d_r=1; otherwise 0.
  - Zero latency; reflects pre-edge state.
  - Unmapped address reads 0.
- Write path: on edge with d_w=1, the addressed register or RAM word takes ddata_w.
  - Writes to SW, STATUS bits[31:1] and unmapped addresses are ignored.
- d_r and d_w both high, same address: ddata_r shows old value this cycle; new value is visible next cycle.
- bus_err is registered; it is 1 the cycle after any d_r or d_w to an unmapped address, else 0.
- MTIME:
  - When cnt_en=1, MTIME increments by 1 per cycle, wrapping 0xFFFFFFFF→0.
  - A write to MTIME loads ddata_w and suppresses that cycle's increment.
  - When cnt_en=0, MTIME holds.
- Match:
  - Each cycle cnt_en=1 and MTIME==MTIMECMP (pre-edge values), STATUS.bit0 is set at the edge.
  - Match is evaluated even on a cycle where MTIME is being written.
- STATUS W1C: write with ddata_w[0]=1 clears bit0. If a match-set occurs in the same cycle, set wins.
- irq = STATUS.bit0 & irq_en; combinational from registers.
- SW: sw_in passes a 2-flop synchronizer; read returns stage-2 value zero-extended to 32 bits.
  - A change on sw_in is readable 2 edges later.
- leds = LED[LED_WIDTH-1:0]; bits above LED_WIDTH are stored and read back.
- RST asserted mid-operation: all registers return to reset values at that edge; any concurrent write is discarded.

Test Plan:
- RAM round trip: write 0xDEADBEEF @ 0x005, then d_r @ 0x005 → ddata_r=0xDEADBEEF; d_r=0 → ddata_r=0.
- Read-during-write: word 0x010 holds 0x11111111; d_r=d_w=1 @ 0x010 with ddata_w=0x22222222 → ddata_r=0x11111111 that cycle, 0x22222222 next cycle.
- Timer/IRQ:
  - Write MTIMECMP=10, then CTRL=3; MTIME counts 0,1,2…
  - STATUS.bit0 and irq rise the edge after MTIME==10.
  - Write STATUS=1 → irq=0 next cycle.
  - Write CTRL=2 → irq stays 0 on the next match.
- Wrap and W1C priority:
  - Write MTIME=0xFFFFFFFE with cnt_en=1 → reads 0xFFFFFFFF, then 0x00000000.
  - With MTIMECMP=MTIME, W1C in the same cycle as a match → bit0 remains 1.
- Switch sync and LEDs:
  - sw_in 0x0000→0xA5A5 → SW reads 0 for 1 edge, 0x0000A5A5 after 2 edges.
  - Write LED=0x12345678 → leds=0x5678, readback 0x12345678.
- Errors and reset:
  - d_r @ 0x3FA → ddata_r=0, bus_err=1 for exactly the next cycle.
  - Assert RST while d_w @ 0x3F0 = 0xFFFF → leds=0, MTIME=0, MTIMECMP=0xFFFFFFFF after that edge.
